c3_result_writeback_queue: RTL and testbench
============================================

// Module: c3_result_writeback_queue
// PURPOSE
//  Downstream stage of the C3 custom SIMD unit. The C3 unit has fixed latency and no backpressure.
//  This block captures every C3 result (scalar rd/data plus two vector dest/data pairs) into a FIFO.
//  It drains entries to the register-file writeback arbiter through a valid/ready handshake.
//  It issues credits upstream so decode never issues more C3 ops than the queue can absorb.
// PARAMETERS
//  DEPTH       4              queue entries, power of two, >= `c3_pipe_cycles+1
//  PIPE_LAT    `c3_pipe_cycles  C3 unit latency (cycles from issue to result)
//  VW          `VLEN          vector data width
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  issue_v      in   1      decode issues a C3 op this cycle (only legal when issue_ok=1)
//  issue_ok     out  1      credit available: upstream may issue a C3 op
//  in_v         in   1      C3 result valid
//  in_rd        in   5      scalar destination
//  in_vrd1      in   3      vector destination 1
//  in_vrd2      in   3      vector destination 2
//  in_data      in   32     scalar result
//  in_vdata1    in   VW     vector result 1
//  in_vdata2    in   VW     vector result 2
//  out_v        out  1      head entry valid
//  out_ready    in   1      writeback arbiter accepts head
//  out_rd/out_vrd1/out_vrd2/out_data/out_vdata1/out_vdata2  out  as inputs  head entry fields
//  occupancy    out  log2(DEPTH)+1  stored entries
//  overflow_err out  1      sticky: a result arrived while the queue was full (dropped)
// BEHAVIOUR
//  - Reset: rd_ptr, wr_ptr, occupancy, inflight and overflow_err go to 0. out_v=0. issue_ok=1 the cycle after reset.
//  - Push: in_v=1 and (occupancy<DEPTH or pop this cycle) -> entry written at wr_ptr; wr_ptr+1 mod DEPTH.
//  - Pop: out_v & out_ready -> rd_ptr+1 mod DEPTH. Outputs are driven directly from the entry at rd_ptr.
//  - Simultaneous push+pop when full: both occur and occupancy is unchanged. When empty, see bypass.
//  - in_v while full with no pop: entry dropped, overflow_err<=1 (sticky until reset), pointers unchanged.
//  - inflight counter: +1 on issue_v, -1 on in_v, both -> unchanged. Width log2(DEPTH)+1; never wraps.
//  - issue_ok = (occupancy + inflight) < DEPTH, computed from registered values only (conservative).
//    A same-cycle pop does not raise issue_ok until the next cycle.
//  - All fields pass unmodified. in_rd==0 is stored as-is; x0 suppression is the arbiter's job.
//  - Pointer wrap uses mod DEPTH arithmetic with an extra wrap bit: full = ptrs equal and wrap bits differ.
//  - Ordering: strict FIFO. Results leave in C3 completion order, which equals issue order.
//  - out_* fields are don't-care while out_v=0. The bench must not check them.
// CONFIGURATION
//  C3WB_BYPASS_EN defined:
//    - When the queue is empty and in_v=1, the input fields drive out_* combinationally and out_v=1.
//    - If out_ready=1 in that cycle, the entry is consumed and never stored (zero latency).
//    - If out_ready=0, the entry is stored normally.
//  C3WB_BYPASS_EN undefined:
//    - out_* come from storage only. Minimum push-to-out_v latency is 1 cycle.
//  Credit logic is identical in both builds.
// STRUCTURE
//  - Shared header c3_defs: `VLEN, `c3_pipe_cycles, entry field widths/offsets.
//    Entry width = 5+3+3+32+2*VW, as localparam-style defines.
//  - Sub-module c3_wb_fifo_mem: DEPTH x entry-width register array.
//    One write port (we, waddr, wdata), one asynchronous read port (raddr, rdata). No reset on data.
//  - Top level: pointers, occupancy, inflight/credit, overflow flag, optional bypass mux.
// TESTING
//  1. Reset, then single issue -> in_v after PIPE_LAT cycles with in_data=32'h1234, out_ready=1
//     -> out_v next cycle (same cycle with bypass), out_data=32'h1234, occupancy back to 0.
//  2. out_ready=0. Issue back-to-back until issue_ok=0 -> exactly DEPTH ops accepted,
//     occupancy=4 (DEPTH=4), overflow_err=0.
//  3. Full queue, push and pop in the same cycle -> occupancy stays 4; popped entry is oldest; FIFO order held over 16 ops.
//  4. Force in_v while full with no pop (credit violation) -> overflow_err=1 sticky; stored entries unchanged.
//  5. Pointer wrap: 3*DEPTH ops with random out_ready (50%) -> outputs match a scoreboard
//     (rd, vrd1, vrd2, data, vdata1, vdata2 = i, i+1 patterns).
//  6. Reset asserted with 3 entries queued and 1 inflight -> next cycle out_v=0, occupancy=0,
//     issue_ok=1, overflow_err=0.

Source files
------------

// File: rtl/c3_result_writeback_queue_pkg.sv
// Shared definitions for the C3 result writeback queue: C3 unit latency,
// vector width, entry field widths and the packed entry width helper.
package c3_result_writeback_queue_pkg;

   // C3 unit latency in cycles from issue to result.
   localparam int C3_PIPE_CYCLES = 3;
   // Vector register width.
   localparam int VLEN           = 64;

   // Entry field widths. Entries are packed MSB-first as
   // {rd, vrd1, vrd2, data, vdata1, vdata2}.
   localparam int RD_W    = 5;
   localparam int VRD_W   = 3;
   localparam int SDATA_W = 32;

   function automatic int entry_w(input int vw);
      return RD_W + 2 * VRD_W + SDATA_W + 2 * vw;
   endfunction

endpackage

// File: rtl/c3_wb_fifo_mem.sv
// Storage array for the C3 writeback queue: one write port and one
// asynchronous read port so the head entry is visible the cycle it is written.
// Data is deliberately not reset; validity is tracked by the pointers.
module c3_wb_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int EW    = 171
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   logic [EW-1:0] mem_q [DEPTH];

   // Write port: capture an entry at waddr.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/c3_result_writeback_queue.sv
// C3 result writeback queue: captures every C3 result into a FIFO, drains it
// to the writeback arbiter over valid/ready and hands out issue credits so
// decode cannot issue more C3 ops than the queue can absorb.
// Optional feature: define C3WB_BYPASS_EN to forward a result straight to the
// outputs when the queue is empty (consumed with zero latency if accepted).
module c3_result_writeback_queue
   import c3_result_writeback_queue_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PIPE_LAT = C3_PIPE_CYCLES,
   parameter int VW       = VLEN
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_v,
   output logic                     issue_ok,
   input  logic                     in_v,
   input  logic [RD_W-1:0]          in_rd,
   input  logic [VRD_W-1:0]         in_vrd1,
   input  logic [VRD_W-1:0]         in_vrd2,
   input  logic [SDATA_W-1:0]       in_data,
   input  logic [VW-1:0]            in_vdata1,
   input  logic [VW-1:0]            in_vdata2,
   output logic                     out_v,
   input  logic                     out_ready,
   output logic [RD_W-1:0]          out_rd,
   output logic [VRD_W-1:0]         out_vrd1,
   output logic [VRD_W-1:0]         out_vrd2,
   output logic [SDATA_W-1:0]       out_data,
   output logic [VW-1:0]            out_vdata1,
   output logic [VW-1:0]            out_vdata2,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_w(VW);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   // Every result in flight must have a slot waiting for it.
   if (DEPTH < PIPE_LAT + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("c3_result_writeback_queue: DEPTH must be a power of two >= PIPE_LAT+1");
   end

   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic          overflow_q, overflow_d;

   logic          empty, full, pop_store, push, consume_bypass;
   logic [EW-1:0] in_entry, mem_rdata, head;
   logic [CW:0]   credit_sum;

   assign in_entry  = {in_rd, in_vrd1, in_vrd2, in_data, in_vdata1, in_vdata2};
   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);

   c3_wb_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .EW    (EW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (in_entry),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (mem_rdata)
   );

`ifdef C3WB_BYPASS_EN
   // Empty queue: present the incoming result directly; an accepted one is never stored.
   assign out_v          = !empty || in_v;
   assign head           = empty ? in_entry : mem_rdata;
   assign consume_bypass = empty && in_v && out_ready;
`else
   assign out_v          = !empty;
   assign head           = mem_rdata;
   assign consume_bypass = 1'b0;
`endif

   assign pop_store = !empty && out_ready;
   assign push      = in_v && (!full || pop_store) && !consume_bypass;

   assign out_rd     = head[EW-1 -: RD_W];
   assign out_vrd1   = head[EW-RD_W-1 -: VRD_W];
   assign out_vrd2   = head[EW-RD_W-VRD_W-1 -: VRD_W];
   assign out_data   = head[2*VW +: SDATA_W];
   assign out_vdata1 = head[VW +: VW];
   assign out_vdata2 = head[0 +: VW];

   // Credits use registered state only, so a same-cycle pop frees a slot one cycle late.
   assign credit_sum   = {1'b0, occupancy} + {1'b0, inflight_q};
   assign issue_ok     = credit_sum < (CW+1)'(DEPTH);
   assign overflow_err = overflow_q;

   // Next-state: pointers, in-flight count and the sticky drop flag.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      inflight_d = inflight_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_store) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (in_v && full && !pop_store) begin
         overflow_d = 1'b1;
      end
      // Saturate rather than wrap if upstream ever violates the credit protocol.
      if (issue_v && !in_v && inflight_q != CNT_MAX) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!issue_v && in_v && inflight_q != '0) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_c3_result_writeback_queue.sv
// Directed testbench for c3_result_writeback_queue (default build; the
// C3WB_BYPASS_EN variant is handled where latency differs).
module tb_c3_result_writeback_queue;
   import c3_result_writeback_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int PL    = C3_PIPE_CYCLES;
   localparam int VW    = VLEN;
`ifdef C3WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  rd;
      logic [2:0]  vrd1;
      logic [2:0]  vrd2;
      logic [31:0] data;
      logic [VW-1:0] vdata1;
      logic [VW-1:0] vdata2;
   } ent_t;

   logic clk = 1'b0;
   logic reset, issue_v, issue_ok, in_v, out_v, out_ready, overflow_err;
   logic [4:0]  in_rd, out_rd;
   logic [2:0]  in_vrd1, in_vrd2, out_vrd1, out_vrd2;
   logic [31:0] in_data, out_data;
   logic [VW-1:0] in_vdata1, in_vdata2, out_vdata1, out_vdata2;
   logic [2:0]  occupancy;

   c3_result_writeback_queue #(.DEPTH(DEPTH), .PIPE_LAT(PL), .VW(VW)) dut (
      .clk(clk), .reset(reset), .issue_v(issue_v), .issue_ok(issue_ok),
      .in_v(in_v), .in_rd(in_rd), .in_vrd1(in_vrd1), .in_vrd2(in_vrd2),
      .in_data(in_data), .in_vdata1(in_vdata1), .in_vdata2(in_vdata2),
      .out_v(out_v), .out_ready(out_ready), .out_rd(out_rd),
      .out_vrd1(out_vrd1), .out_vrd2(out_vrd2), .out_data(out_data),
      .out_vdata1(out_vdata1), .out_vdata2(out_vdata2),
      .occupancy(occupancy), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   int   vecs = 0;
   int   errs = 0;
   int   next_id = 0;
   bit   pipe[$];
   ent_t sb[$];
   bit   obs_v, exp_v, exp_pop;
   ent_t obs_e, exp_e;

   function automatic ent_t mk(input int id);
      ent_t e;
      e.rd     = 5'(id);
      e.vrd1   = 3'(id + 1);
      e.vrd2   = 3'(id + 2);
      e.data   = 32'h1234 + 32'(id) * 32'h1111;
      e.vdata1 = {32'(id), 32'(id + 1)};
      e.vdata2 = {~32'(id + 1), 32'(id)};
      return e;
   endfunction

   task automatic clear_model();
      pipe.delete();
      for (int i = 0; i < PL; i++) pipe.push_back(1'b0);
      sb.delete();
   endtask

   // One clock: drive inputs, sample outputs mid-cycle, advance the reference queue.
   task automatic cyc(input bit iss, input bit force_v, input bit rdy);
      bit   pv, acc;
      ent_t e;
      pv = pipe.pop_front();
      pipe.push_back(iss);
      e = mk(next_id);
      issue_v = iss;
      in_v = pv | force_v;
      out_ready = rdy;
      {in_rd, in_vrd1, in_vrd2, in_data, in_vdata1, in_vdata2} = e;
      #1;
      obs_v = out_v;
      obs_e = {out_rd, out_vrd1, out_vrd2, out_data, out_vdata1, out_vdata2};
      exp_v = (sb.size() > 0) || (BYP && in_v);
      exp_pop = exp_v && rdy;
      acc = in_v && ((sb.size() < DEPTH) || exp_pop);
      if (in_v) next_id++;
      if (acc) sb.push_back(e);
      if (exp_pop) begin
         exp_e = sb.pop_front();
         $display("pop: out_rd=%0d out_data=%h (ref rd=%0d data=%h)", out_rd, out_data, exp_e.rd, exp_e.data);
      end
      @(posedge clk);
      #1;
      issue_v = 1'b0;
      in_v = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; issue_v = 1'b0; in_v = 1'b0; out_ready = 1'b0;
      {in_rd, in_vrd1, in_vrd2, in_data, in_vdata1, in_vdata2} = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_model();
      vecs++; if (out_v !== 1'b0) begin errs++; $display("FAIL reset_out_v: got %b want 0", out_v); end
      vecs++; if (occupancy !== 3'd0) begin errs++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      vecs++; if (issue_ok !== 1'b1) begin errs++; $display("FAIL reset_issue_ok: got %b want 1", issue_ok); end
      vecs++; if (overflow_err !== 1'b0) begin errs++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
   endtask

   task automatic test_single();
      cyc(1'b1, 1'b0, 1'b1);
      repeat (PL - 1) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);                     // result arrives this cycle
      if (BYP) begin
         vecs++; if (obs_v !== 1'b1) begin errs++; $display("FAIL single_bypass_v: got %b want 1", obs_v); end
         vecs++; if (obs_e.data !== 32'h1234) begin errs++; $display("FAIL single_bypass_data: got %h want 00001234", obs_e.data); end
      end else begin
         vecs++; if (obs_v !== 1'b0) begin errs++; $display("FAIL single_latency_v: got %b want 0", obs_v); end
         cyc(1'b0, 1'b0, 1'b1);
         vecs++; if (obs_v !== 1'b1) begin errs++; $display("FAIL single_out_v: got %b want 1", obs_v); end
         vecs++; if (obs_e.data !== 32'h1234) begin errs++; $display("FAIL single_data: got %h want 00001234", obs_e.data); end
      end
      vecs++; if (occupancy !== 3'd0) begin errs++; $display("FAIL single_occ: got %0d want 0", occupancy); end
      vecs++; if (issue_ok !== 1'b1) begin errs++; $display("FAIL single_issue_ok: got %b want 1", issue_ok); end
   endtask

   task automatic test_credit_fill();
      int issued = 0;
      bit iss;
      for (int c = 0; c < 12; c++) begin
         iss = issue_ok;
         cyc(iss, 1'b0, 1'b0);
         issued += int'(iss);
      end
      repeat (PL) cyc(1'b0, 1'b0, 1'b0);
      vecs++; if (issued != DEPTH) begin errs++; $display("FAIL credit_issued: got %0d want %0d", issued, DEPTH); end
      vecs++; if (occupancy !== 3'd4) begin errs++; $display("FAIL credit_occ: got %0d want 4", occupancy); end
      vecs++; if (overflow_err !== 1'b0) begin errs++; $display("FAIL credit_overflow: got %b want 0", overflow_err); end
      vecs++; if (issue_ok !== 1'b0) begin errs++; $display("FAIL credit_issue_ok: got %b want 0", issue_ok); end
      vecs++; if (out_v !== 1'b1) begin errs++; $display("FAIL credit_out_v: got %b want 1", out_v); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, 1'b1, 1'b1);
         vecs++; if (obs_v !== 1'b1) begin errs++; $display("FAIL fullpp_v[%0d]: got %b want 1", k, obs_v); end
         vecs++; if (obs_e !== exp_e) begin errs++; $display("FAIL fullpp_entry[%0d]: got rd=%0d data=%h want rd=%0d data=%h", k, obs_e.rd, obs_e.data, exp_e.rd, exp_e.data); end
         vecs++; if (occupancy !== 3'd4) begin errs++; $display("FAIL fullpp_occ[%0d]: got %0d want 4", k, occupancy); end
      end
   endtask

   task automatic test_overflow();
      cyc(1'b0, 1'b1, 1'b0);                     // dropped: full, no pop
      vecs++; if (overflow_err !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
      vecs++; if (occupancy !== 3'd4) begin errs++; $display("FAIL ovf_occ: got %0d want 4", occupancy); end
      for (int k = 0; k < DEPTH; k++) begin
         cyc(1'b0, 1'b0, 1'b1);
         vecs++; if (obs_e !== exp_e) begin errs++; $display("FAIL ovf_drain[%0d]: got rd=%0d data=%h want rd=%0d data=%h", k, obs_e.rd, obs_e.data, exp_e.rd, exp_e.data); end
      end
      cyc(1'b0, 1'b0, 1'b1);
      vecs++; if (occupancy !== 3'd0) begin errs++; $display("FAIL ovf_occ_drained: got %0d want 0", occupancy); end
      vecs++; if (overflow_err !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
   endtask

   task automatic test_wrap();
      int issued = 0;
      int popped = 0;
      int c = 0;
      bit iss;
      while (popped < 3 * DEPTH && c < 300) begin
         iss = issue_ok && (issued < 3 * DEPTH);
         cyc(iss, 1'b0, 1'($urandom_range(0, 1)));
         issued += int'(iss);
         vecs++; if (obs_v !== exp_v) begin errs++; $display("FAIL wrap_v[%0d]: got %b want %b", c, obs_v, exp_v); end
         if (exp_pop) begin
            popped++;
            vecs++; if (obs_e !== exp_e) begin errs++; $display("FAIL wrap_entry[%0d]: got rd=%0d data=%h want rd=%0d data=%h", c, obs_e.rd, obs_e.data, exp_e.rd, exp_e.data); end
         end
         c++;
      end
      vecs++; if (popped != 3 * DEPTH) begin errs++; $display("FAIL wrap_timeout: popped %0d want %0d", popped, 3 * DEPTH); end
      vecs++; if (occupancy !== 3'd0) begin errs++; $display("FAIL wrap_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_reset_midflight();
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      vecs++; if (occupancy !== 3'd3) begin errs++; $display("FAIL rstmid_pre_occ: got %0d want 3", occupancy); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      vecs++; if (out_v !== 1'b0) begin errs++; $display("FAIL rstmid_out_v: got %b want 0", out_v); end
      vecs++; if (occupancy !== 3'd0) begin errs++; $display("FAIL rstmid_occ: got %0d want 0", occupancy); end
      vecs++; if (issue_ok !== 1'b1) begin errs++; $display("FAIL rstmid_issue_ok: got %b want 1", issue_ok); end
      vecs++; if (overflow_err !== 1'b0) begin errs++; $display("FAIL rstmid_overflow: got %b want 0", overflow_err); end
      reset = 1'b0;
      clear_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_credit_fill();
      test_full_push_pop();
      test_overflow();
      test_wrap();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
